// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared types and constants for the IF stage
package pc_fetch_unit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;

    localparam logic [31:0] NOP_INST      = 32'h0;
    localparam logic [31:0] ZERO_WORD     = 32'h0;
    localparam logic        REQ_ENABLE    = 1'b1;
    localparam logic        BRANCH_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_FETCH   = 2'd1,
        IF_HOLD    = 2'd2,
        IF_DISCARD = 2'd3
    } if_state_e;

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// rtl/pc_fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, bubble and hold
module pc_fetch_unit_if_id_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [DATA_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_plus4_q;
    logic [DATA_W-1:0] inst_q;
    logic              valid_q;

    // A bubble keeps pc_plus4 so ID still sees the last real sequential address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_plus4_q <= ADDR_W'(ZERO_WORD);
            inst_q     <= DATA_W'(NOP_INST);
            valid_q    <= 1'b0;
        end else if (bubble_i) begin
            inst_q     <= DATA_W'(NOP_INST);
            valid_q    <= 1'b0;
        end else if (load_i) begin
            pc_plus4_q <= pc_plus4_i;
            inst_q     <= inst_i;
            valid_q    <= 1'b1;
        end
    end

    assign pc_plus4_o = pc_plus4_q;
    assign inst_o     = inst_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, imem req/ack fetch FSM and IF/ID register
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_branch,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              stall_IF,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_IF,
    output logic [ADDR_W-1:0] pc_plus4_ID,
    output logic [DATA_W-1:0] inst_ID,
    output logic              valid_ID
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] pc_plus4, target;
    logic [DATA_W-1:0] ld_inst;
    logic              redir, ld, bub;
    logic              unused_addr_lsb;

    assign redir           = (is_branch == BRANCH_ENABLE) & valid_ID & ~stall_IF;
    assign target          = {branch_address[ADDR_W-1:2], 2'b00};
    assign pc_plus4        = pc_q + ADDR_W'(4);
    assign unused_addr_lsb = ^branch_address[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        skid_d  = skid_q;
        ld_inst = imem_rdata;
        ld      = 1'b0;
        bub     = 1'b0;
        case (state_q)
            IF_IDLE: state_d = IF_FETCH;
            IF_FETCH: begin
                if (imem_ack) begin
                    if (redir) begin
                        pc_d = target;
                        bub  = 1'b1;
                    end else if (!stall_IF) begin
                        ld   = 1'b1;
                        pc_d = pc_plus4;
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = IF_HOLD;
                    end
                end else if (redir) begin
                    pc_d    = target;
                    bub     = 1'b1;
                    state_d = IF_DISCARD;
                end else if (!stall_IF) begin
                    bub = 1'b1;
                end
            end
            IF_HOLD: begin
                if (redir) begin
                    pc_d    = target;
                    bub     = 1'b1;
                    state_d = IF_FETCH;
                end else if (!stall_IF) begin
                    ld      = 1'b1;
                    ld_inst = skid_q;
                    pc_d    = pc_plus4;
                    state_d = IF_FETCH;
                end
            end
            IF_DISCARD: begin
                // The outstanding handshake must finish; its data is wrong-path.
                if (redir) pc_d = target;
                bub = ~stall_IF;
                if (imem_ack) state_d = IF_FETCH;
            end
            default: state_d = IF_IDLE;
        endcase
    end

    assign req_addr_d  = (state_q == IF_FETCH) ? pc_q : req_addr_q;
    assign imem_req_d  = (state_d == IF_FETCH || state_d == IF_DISCARD) ? REQ_ENABLE : ~REQ_ENABLE;
    assign imem_addr_d = (state_d == IF_DISCARD) ? req_addr_d : pc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            skid_q      <= DATA_W'(NOP_INST);
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            skid_q      <= skid_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign pc_IF     = pc_q;

    pc_fetch_unit_if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (ld),
        .bubble_i   (bub),
        .pc_plus4_i (pc_plus4),
        .inst_i     (ld_inst),
        .pc_plus4_o (pc_plus4_ID),
        .inst_o     (inst_ID),
        .valid_o    (valid_ID)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed-vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        is_branch;
    logic [31:0] branch_address;
    logic        stall_IF;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IF;
    logic [31:0] pc_plus4_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;

    int n_vec;
    int n_bad;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .is_branch      (is_branch),
        .branch_address (branch_address),
        .stall_IF       (stall_IF),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_IF          (pc_IF),
        .pc_plus4_ID    (pc_plus4_ID),
        .inst_ID        (inst_ID),
        .valid_ID       (valid_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word derived from the requested address.
    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic ack, input logic br, input logic [31:0] ba, input logic st);
        imem_ack       = ack;
        is_branch      = br;
        branch_address = ba;
        stall_IF       = st;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 1'b0);
        tick;
        tick;
        expect_eq("rst_req",   32'(imem_req), 32'h0);
        expect_eq("rst_addr",  imem_addr, 32'h0);
        expect_eq("rst_pc",    pc_IF, 32'h0);
        expect_eq("rst_valid", 32'(valid_ID), 32'h0);
        expect_eq("rst_inst",  inst_ID, 32'h0);
        expect_eq("rst_pc4",   pc_plus4_ID, 32'h0);

        rst = 1'b1;
        tick;
        expect_eq("idle_to_fetch_req", 32'(imem_req), 32'h1);
        expect_eq("idle_to_fetch_addr", imem_addr, 32'h0);

        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("seq1_addr", imem_addr, 32'h4);
        expect_eq("seq1_inst", inst_ID, w(32'h0));
        tick;
        expect_eq("seq2_addr", imem_addr, 32'h8);
        tick;
        expect_eq("seq3_inst",  inst_ID, w(32'h8));
        expect_eq("seq3_pc4",   pc_plus4_ID, 32'hC);
        expect_eq("seq3_valid", 32'(valid_ID), 32'h1);
        expect_eq("seq3_addr",  imem_addr, 32'hC);

        drv(1'b1, 1'b1, 32'h40, 1'b0);
        tick;
        expect_eq("br_addr",  imem_addr, 32'h40);
        expect_eq("br_valid", 32'(valid_ID), 32'h0);
        expect_eq("br_pc4",   pc_plus4_ID, 32'hC);
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("br_tgt_inst", inst_ID, w(32'h40));
        expect_eq("br_tgt_pc4",  pc_plus4_ID, 32'h44);
        expect_eq("br_tgt_valid", 32'(valid_ID), 32'h1);

        drv(1'b1, 1'b1, 32'hC, 1'b0);
        tick;
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("pre_disc_addr", imem_addr, 32'h10);
        expect_eq("pre_disc_inst", inst_ID, w(32'hC));
        drv(1'b0, 1'b1, 32'h80, 1'b0);
        tick;
        expect_eq("disc0_addr",  imem_addr, 32'h10);
        expect_eq("disc0_req",   32'(imem_req), 32'h1);
        expect_eq("disc0_pc",    pc_IF, 32'h80);
        expect_eq("disc0_valid", 32'(valid_ID), 32'h0);
        drv(1'b0, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("disc1_addr", imem_addr, 32'h10);
        tick;
        expect_eq("disc2_addr",  imem_addr, 32'h10);
        expect_eq("disc2_valid", 32'(valid_ID), 32'h0);
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("disc_ack_addr",  imem_addr, 32'h80);
        expect_eq("disc_ack_valid", 32'(valid_ID), 32'h0);
        tick;
        expect_eq("disc_tgt_inst", inst_ID, w(32'h80));
        expect_eq("disc_tgt_pc4",  pc_plus4_ID, 32'h84);

        drv(1'b1, 1'b1, 32'h1C, 1'b0);
        tick;
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("pre_stall_addr", imem_addr, 32'h20);
        drv(1'b1, 1'b0, 32'h0, 1'b1);
        tick;
        expect_eq("hold0_req",   32'(imem_req), 32'h0);
        expect_eq("hold0_inst",  inst_ID, w(32'h1C));
        expect_eq("hold0_valid", 32'(valid_ID), 32'h1);
        drv(1'b0, 1'b1, 32'h200, 1'b1);
        tick;
        expect_eq("hold1_req",  32'(imem_req), 32'h0);
        expect_eq("hold1_inst", inst_ID, w(32'h1C));
        expect_eq("stall_br_ignored_pc", pc_IF, 32'h20);
        drv(1'b0, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("skid_inst",  inst_ID, w(32'h20));
        expect_eq("skid_pc4",   pc_plus4_ID, 32'h24);
        expect_eq("skid_valid", 32'(valid_ID), 32'h1);
        expect_eq("skid_addr",  imem_addr, 32'h24);
        expect_eq("skid_req",   32'(imem_req), 32'h1);
        tick;
        expect_eq("skid_once_valid", 32'(valid_ID), 32'h0);

        drv(1'b1, 1'b1, 32'h300, 1'b0);
        tick;
        expect_eq("inv_br_ignored_addr", imem_addr, 32'h28);
        expect_eq("inv_br_ignored_pc4",  pc_plus4_ID, 32'h28);
        drv(1'b1, 1'b1, 32'h103, 1'b0);
        tick;
        expect_eq("align_pc",   pc_IF, 32'h100);
        expect_eq("align_addr", imem_addr, 32'h100);

        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        drv(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick;
        expect_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("wrap_pc",   pc_IF, 32'h0);
        expect_eq("wrap_pc4",  pc_plus4_ID, 32'h0);
        expect_eq("wrap_inst", inst_ID, w(32'hFFFF_FFFC));
        tick;
        drv(1'b0, 1'b1, 32'h500, 1'b0);
        tick;
        expect_eq("rdisc_addr", imem_addr, 32'h4);
        expect_eq("rdisc_pc",   pc_IF, 32'h500);
        drv(1'b0, 1'b0, 32'h0, 1'b0);
        #2 rst = 1'b0;
        #1;
        expect_eq("async_rst_req",   32'(imem_req), 32'h0);
        expect_eq("async_rst_addr",  imem_addr, 32'h0);
        expect_eq("async_rst_pc",    pc_IF, 32'h0);
        expect_eq("async_rst_valid", 32'(valid_ID), 32'h0);
        expect_eq("async_rst_pc4",   pc_plus4_ID, 32'h0);
        tick;
        expect_eq("in_rst_req", 32'(imem_req), 32'h0);

        rst = 1'b1;
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        expect_eq("restart_req",   32'(imem_req), 32'h1);
        expect_eq("restart_addr",  imem_addr, 32'h0);
        expect_eq("stray_ack_valid", 32'(valid_ID), 32'h0);
        tick;
        expect_eq("restart_inst", inst_ID, w(32'h0));
        expect_eq("restart_pc4",  pc_plus4_ID, 32'h4);
        expect_eq("restart_addr2", imem_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
